regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_sb.sv | 93 +++++++++
 tb/tb_regfile_sb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DefaultXlen     = 32;
  localparam int unsigned DefaultRegCount = 32;
  localparam int unsigned DefaultNrd      = 2;
  localparam int unsigned DefaultNwr      = 1;

  // Architectural zero register: hardwired to zero, never reserved.
  localparam int unsigned ZeroReg = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer.
// Priority: flush clears everything, otherwise a new reservation beats a
// same-cycle write-back clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned REG_COUNT = DefaultRegCount,
  parameter int unsigned AW        = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 flush,
  input  logic [REG_COUNT-1:0] clr_vec,
  output logic [REG_COUNT-1:0] busy_vec
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZeroReg);

  logic [REG_COUNT-1:0] busy_q, busy_d, set_vec;

  // Next busy state from issue (set), write-back (clear) and flush.
  always_comb begin
    set_vec = '0;
    if (iss_valid && (iss_rd != ZeroAddr)) begin
      set_vec[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = (busy_q & ~clr_vec) | set_vec;
    end
    busy_d[ZeroReg] = 1'b0;
  end

  // Busy register; reset drops every pending reservation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with write-first bypass and an issue scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = DefaultXlen,
  parameter int unsigned REG_COUNT = DefaultRegCount,
  parameter int unsigned NRD       = DefaultNrd,
  parameter int unsigned NWR       = DefaultNwr,
  parameter int unsigned AW        = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 flush,
  output logic [REG_COUNT-1:0] busy_vec
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZeroReg);

  logic [XLEN-1:0]      mem_q [REG_COUNT];
  logic [NWR-1:0]       wr_ok;
  logic [REG_COUNT-1:0] clr_vec;
  logic [AW-1:0]        rd_addr [NRD];
  logic [XLEN-1:0]      rd_val  [NRD];

  // Qualify writes: nonzero, fully-known address; also form the busy-clear vector.
  always_comb begin
    wr_ok   = '0;
    clr_vec = '0;
    for (int w = 0; w < NWR; w++) begin
      wr_ok[w] = we[w] && (waddr[w*AW +: AW] != ZeroAddr) && !$isunknown(waddr[w*AW +: AW]);
      if (wr_ok[w]) begin
        clr_vec[waddr[w*AW +: AW]] = 1'b1;
      end
    end
  end

  // Data array; later write ports overwrite earlier ones on address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w]) begin
          mem_q[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Write-first read ports; outputs forced low while in reset.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_addr[p] = raddr[p*AW +: AW];
      rd_val[p]  = mem_q[rd_addr[p]];
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w] && (waddr[w*AW +: AW] == rd_addr[p])) begin
          rd_val[p] = wdata[w*XLEN +: XLEN];
        end
      end
      if (rst_n && (rd_addr[p] != ZeroAddr)) begin
        rdata[p*XLEN +: XLEN] = rd_val[p];
        // A same-cycle write-back supplies the value, so the port is not busy.
        rbusy[p] = busy_vec[rd_addr[p]] && !clr_vec[rd_addr[p]];
      end
    end
  end

  regfile_scoreboard #(
    .REG_COUNT(REG_COUNT),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .flush    (flush),
    .clr_vec  (clr_vec),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: directed vector table, reset sequences, and random
// traffic compared against an array-based reference model.
module tb_regfile_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RC   = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NWR  = 2;
  localparam int unsigned AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRD*AW-1:0]   raddr = '0;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we = '0;
  logic [NWR*AW-1:0]   waddr = '0;
  logic [NWR*XLEN-1:0] wdata = '0;
  logic                iss_valid = 1'b0;
  logic [AW-1:0]       iss_rd = '0;
  logic                flush = 1'b0;
  logic [RC-1:0]       busy_vec;

  always #5 clk = ~clk;

  regfile_sb #(
    .XLEN     (XLEN),
    .REG_COUNT(RC),
    .NRD      (NRD),
    .NWR      (NWR),
    .AW       (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents and pending set.
  logic [XLEN-1:0] m_mem [RC];
  bit              m_busy [RC];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] e_rd;
    logic        e_rb;
    logic [31:0] e_bv;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RC; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic bit written(input int a);
    return (we[0] && (int'(waddr[4:0]) == a)) || (we[1] && (int'(waddr[9:5]) == a));
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int a);
    logic [XLEN-1:0] v;
    if (!rst_n || a == 0) return '0;
    v = m_mem[a];
    if (we[0] && int'(waddr[4:0]) == a) v = wdata[31:0];
    if (we[1] && int'(waddr[9:5]) == a) v = wdata[63:32];
    return v;
  endfunction

  function automatic logic exp_rb(input int a);
    if (!rst_n || a == 0) return 1'b0;
    return m_busy[a] && !written(a);
  endfunction

  function automatic logic [RC-1:0] exp_bv();
    logic [RC-1:0] v;
    for (int i = 0; i < RC; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Apply the architectural effect of the current inputs at a rising edge.
  task automatic model_edge();
    int a0, a1;
    if (!rst_n) return;
    a0 = int'(waddr[4:0]);
    a1 = int'(waddr[9:5]);
    if (we[0] && a0 != 0) m_mem[a0] = wdata[31:0];
    if (we[1] && a1 != 0) m_mem[a1] = wdata[63:32];
    if (flush) begin
      for (int i = 0; i < RC; i++) m_busy[i] = 1'b0;
    end else begin
      if (we[0] && a0 != 0) m_busy[a0] = 1'b0;
      if (we[1] && a1 != 0) m_busy[a1] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_chk();
    chk("rdata0", 64'(rdata[31:0]), 64'(exp_rd(int'(raddr[4:0]))));
    chk("rdata1", 64'(rdata[63:32]), 64'(exp_rd(int'(raddr[9:5]))));
    chk("rbusy0", 64'(rbusy[0]), 64'(exp_rb(int'(raddr[4:0]))));
    chk("rbusy1", 64'(rbusy[1]), 64'(exp_rb(int'(raddr[9:5]))));
    chk("busy_vec", 64'(busy_vec), 64'(exp_bv()));
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic rand_inputs();
    we = NWR'($urandom);
    for (int w = 0; w < 2; w++) begin
      waddr[w*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wdata[w*32 +: 32] = $urandom;
    end
    for (int p = 0; p < 2; p++) begin
      raddr[p*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    end
    iss_valid = 1'($urandom);
    iss_rd    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    flush     = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    model_reset();
    vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd5, 1'b0, 5'd0, 1'b0,
                 32'hDEADBEEF, 1'b0, 32'd0};
    vecs[1]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 1'b0, 5'd0, 1'b0,
                 32'hDEADBEEF, 1'b0, 32'd0};
    vecs[2]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd7, 1'b0, 5'd0, 1'b0,
                 32'h22, 1'b0, 32'd0};
    vecs[3]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 1'b0, 5'd0, 1'b0,
                 32'h22, 1'b0, 32'd0};
    vecs[4]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 1'b1, 5'd9, 1'b0,
                 32'd0, 1'b0, 32'd0};
    vecs[5]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 1'b0, 5'd0, 1'b0,
                 32'd0, 1'b1, 32'h200};
    vecs[6]  = '{2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 5'd9, 1'b0, 5'd0, 1'b0,
                 32'h99, 1'b0, 32'h200};
    vecs[7]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 1'b0, 5'd0, 1'b0,
                 32'h99, 1'b0, 32'd0};
    vecs[8]  = '{2'b01, 5'd4, 32'h44, 5'd0, 32'd0, 5'd4, 1'b1, 5'd4, 1'b0,
                 32'h44, 1'b0, 32'd0};
    vecs[9]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 1'b0, 5'd0, 1'b0,
                 32'h44, 1'b1, 32'h10};
    vecs[10] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 1'b0, 5'd0, 1'b1,
                 32'h44, 1'b1, 32'h10};
    vecs[11] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 1'b0, 5'd0, 1'b0,
                 32'h44, 1'b0, 32'd0};
    vecs[12] = '{2'b01, 5'd0, 32'hFFFF, 5'd0, 32'd0, 5'd0, 1'b1, 5'd0, 1'b0,
                 32'd0, 1'b0, 32'd0};
    vecs[13] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                 32'd0, 1'b0, 32'd0};
    vecs[14] = '{2'b01, 5'd3, 32'h33, 5'd0, 32'd0, 5'd3, 1'b1, 5'd3, 1'b1,
                 32'h33, 1'b0, 32'd0};
    vecs[15] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 1'b0, 5'd0, 1'b0,
                 32'h33, 1'b0, 32'd0};

    // Outputs during reset, even with a write presented.
    #2;
    we = 2'b01; waddr = 10'd6; wdata = 64'h1234;
    raddr = {5'd6, 5'd6};
    #1;
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_rbusy", 64'(rbusy), 64'd0);
    chk("reset_busy", 64'(busy_vec), 64'd0);
    idle();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Every address reads zero and nothing is busy after reset.
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      chk("init_rdata", 64'(rdata), 64'd0);
      chk("init_rbusy", 64'(rbusy), 64'd0);
    end
    chk("init_busy", 64'(busy_vec), 64'd0);

    // Directed vectors, one per cycle.
    for (int i = 0; i < 16; i++) begin
      we = vecs[i].we;
      waddr = {vecs[i].wa1, vecs[i].wa0};
      wdata = {vecs[i].wd1, vecs[i].wd0};
      raddr = {5'd0, vecs[i].ra0};
      iss_valid = vecs[i].iv;
      iss_rd = vecs[i].ird;
      flush = vecs[i].fl;
      #2;
      chk($sformatf("vec%0d_rdata0", i), 64'(rdata[31:0]), 64'(vecs[i].e_rd));
      chk($sformatf("vec%0d_rbusy0", i), 64'(rbusy[0]), 64'(vecs[i].e_rb));
      chk($sformatf("vec%0d_busy", i), 64'(busy_vec), 64'(vecs[i].e_bv));
      chk($sformatf("vec%0d_rdata1", i), 64'(rdata[63:32]), 64'd0);
      adv();
    end
    idle();

    // Random traffic against the model, with one mid-run reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        idle();
        iss_valid = 1'b1; iss_rd = 5'd10;
        adv();
        idle();
        raddr = {5'd10, 5'd10};
        #1;
        chk("pre_rst_busy", 64'(busy_vec[10]), 64'd1);
        rst_n = 1'b0;
        model_reset();
        we = 2'b01; waddr = 10'd10; wdata = 64'h55;
        #1;
        chk("mid_rst_busy", 64'(busy_vec), 64'd0);
        chk("mid_rst_rdata", 64'(rdata), 64'd0);
        chk("mid_rst_rbusy", 64'(rbusy), 64'd0);
        adv();
        // Release away from the edge; this cycle's write and issue must land.
        rst_n = 1'b1;
        we = 2'b10; waddr = {5'd12, 5'd0}; wdata = {32'hABC, 32'd0};
        iss_valid = 1'b1; iss_rd = 5'd13;
        raddr = {5'd13, 5'd12};
        #1;
        model_chk();
        adv();
        idle();
        #1;
        model_chk();
        chk("post_rst_r12", 64'(rdata[31:0]), 64'hABC);
        chk("post_rst_b13", 64'(busy_vec[13]), 64'd1);
      end
      rand_inputs();
      #2;
      model_chk();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
